// File: rtl/key_event_module_pkg.sv
// Shared key definitions: gesture states, default timing constants and the timer width helper.
package key_event_module_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        HOLD   = 3'd4
    } key_state_t;

    localparam int DEF_MS_CNT    = 50000;
    localparam int DEF_LONG_MS   = 1000;
    localparam int DEF_DOUBLE_MS = 250;
    localparam int DEF_REPEAT_MS = 200;

    // Enough bits to hold the longest timeout in cycles.
    function automatic int timer_width(input int ms_cnt, input int long_ms,
                                       input int double_ms, input int repeat_ms);
        int max_ms;
        max_ms = long_ms;
        if (double_ms > max_ms) max_ms = double_ms;
        if (repeat_ms > max_ms) max_ms = repeat_ms;
        return $clog2(max_ms * ms_cnt + 1);
    endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Registers the clean key level and flags press/release edges combinationally in the edge cycle.
// No backpressure; a key held low through reset is not reported as a press until it is released once.
module key_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic press_edge,
    output logic release_edge
);

    logic key_q;
    logic armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= 1'b1;
            armed <= 1'b0;
        end else begin
            key_q <= key;
            armed <= armed | key;
        end
    end

    // armed masks the apparent press when the key was already down at reset release.
    assign press_edge   = armed & key_q & ~key;
    assign release_edge = ~key_q & key;

endmodule

// File: rtl/key_event_module.sv
// Classifies key gestures into one-cycle short/long/repeat/double pulses, one cycle after the deciding edge or timeout.
// No backpressure; pulses are registered and mutually exclusive.
module key_event_module
    import key_event_module_pkg::*;
#(
    parameter int MS_CNT    = DEF_MS_CNT,
    parameter int LONG_MS   = DEF_LONG_MS,
    parameter int DOUBLE_MS = DEF_DOUBLE_MS,
    parameter int REPEAT_MS = DEF_REPEAT_MS
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic Key_In,
    output logic Short_Sig,
    output logic Long_Sig,
    output logic Repeat_Sig,
    output logic Double_Sig
);

    localparam int TW = timer_width(MS_CNT, LONG_MS, DOUBLE_MS, REPEAT_MS);

    localparam logic [TW-1:0] LONG_TO   = TW'(LONG_MS * MS_CNT - 1);
    localparam logic [TW-1:0] DOUBLE_TO = TW'(DOUBLE_MS * MS_CNT - 1);
    localparam logic [TW-1:0] REPEAT_TO = TW'(REPEAT_MS * MS_CNT - 1);
    localparam logic [TW-1:0] TIMER_MAX = '1;

    logic          press_edge;
    logic          release_edge;
    key_state_t    state;
    key_state_t    state_nxt;
    logic [TW-1:0] timer;
    logic          timer_clr;
    logic          short_nxt;
    logic          long_nxt;
    logic          repeat_nxt;
    logic          double_nxt;

    key_edge_detect u_edge (
        .clk          (CLK),
        .rst_n        (RST_n),
        .key          (Key_In),
        .press_edge   (press_edge),
        .release_edge (release_edge)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            timer <= '0;
        end else if (timer_clr) begin
            timer <= '0;
        end else if (timer != TIMER_MAX) begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state      <= IDLE;
            Short_Sig  <= 1'b0;
            Long_Sig   <= 1'b0;
            Repeat_Sig <= 1'b0;
            Double_Sig <= 1'b0;
        end else begin
            state      <= state_nxt;
            Short_Sig  <= short_nxt;
            Long_Sig   <= long_nxt;
            Repeat_Sig <= repeat_nxt;
            Double_Sig <= double_nxt;
        end
    end

    // Edges take priority over a coincident timeout in every state.
    always_comb begin
        state_nxt  = state;
        short_nxt  = 1'b0;
        long_nxt   = 1'b0;
        repeat_nxt = 1'b0;
        double_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (press_edge) state_nxt = PRESS1;
            end
            PRESS1: begin
                if (release_edge) begin
                    state_nxt = WAIT2;
                end else if (timer == LONG_TO) begin
                    state_nxt = HOLD;
                    long_nxt  = 1'b1;
                end
            end
            WAIT2: begin
                if (press_edge) begin
                    state_nxt  = PRESS2;
                    double_nxt = 1'b1;
                end else if (timer == DOUBLE_TO) begin
                    state_nxt = IDLE;
                    short_nxt = 1'b1;
                end
            end
            PRESS2: begin
                if (release_edge) state_nxt = IDLE;
            end
            HOLD: begin
                if (release_edge) begin
                    state_nxt = IDLE;
                end else if (timer == REPEAT_TO) begin
                    repeat_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        timer_clr = (state_nxt != state) | repeat_nxt;
    end

endmodule

// File: tb/tb_key_event_module.sv
// Randomized and directed gesture checks against a gesture-level reference model.
module tb_key_event_module;
    import key_event_module_pkg::*;

    localparam int MS = 10;
    localparam int L  = 20 * MS;
    localparam int D  = 5 * MS;
    localparam int P  = 4 * MS;
    localparam int BIG = 32'h3fff_ffff;

    logic CLK = 1'b0;
    logic RST_n = 1'b0;
    logic Key_In = 1'b1;
    logic Short_Sig, Long_Sig, Repeat_Sig, Double_Sig;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    bit  rec = 0;
    int  multi_hot = 0;
    int  obs_q[$];
    int  exp_q[$];
    bit  seg_lvl[$];
    int  seg_len[$];
    bit  key_arr[$];

    key_event_module #(
        .MS_CNT(MS), .LONG_MS(20), .DOUBLE_MS(5), .REPEAT_MS(4)
    ) dut (
        .CLK(CLK), .RST_n(RST_n), .Key_In(Key_In),
        .Short_Sig(Short_Sig), .Long_Sig(Long_Sig),
        .Repeat_Sig(Repeat_Sig), .Double_Sig(Double_Sig)
    );

    always #5 CLK = ~CLK;

    initial forever begin
        @(posedge CLK);
        cyc = cyc + 1;
    end

    // Events are encoded as cycle*4 + kind (0 short, 1 long, 2 repeat, 3 double).
    initial begin : monitor
        int n;
        forever begin
            @(negedge CLK);
            if (rec) begin
                n = int'(Short_Sig) + int'(Long_Sig) + int'(Repeat_Sig) + int'(Double_Sig);
                if (n > 1) multi_hot++;
                if (Short_Sig)  obs_q.push_back(cyc * 4 + 0);
                if (Long_Sig)   obs_q.push_back(cyc * 4 + 1);
                if (Repeat_Sig) obs_q.push_back(cyc * 4 + 2);
                if (Double_Sig) obs_q.push_back(cyc * 4 + 3);
            end
        end
    end

    function automatic int ev(input int t, input int kind);
        return t * 4 + kind;
    endfunction

    task automatic start(input bit lvl);
        RST_n = 1'b0;
        Key_In = lvl;
        rec = 0;
        obs_q.delete();
        exp_q.delete();
        seg_lvl.delete();
        seg_len.delete();
        repeat (3) @(posedge CLK);
        #1;
        RST_n = 1'b1;
        cyc = 0;
        multi_hot = 0;
        rec = 1;
    endtask

    task automatic seg(input bit lvl, input int len);
        seg_lvl.push_back(lvl);
        seg_len.push_back(len);
    endtask

    task automatic play();
        foreach (seg_len[i]) begin
            repeat (seg_len[i]) begin
                Key_In = seg_lvl[i];
                @(posedge CLK);
                #1;
            end
        end
        rec = 0;
    endtask

    function automatic int first_diff();
        int n;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (obs_q[i] != exp_q[i]) return i;
        if (obs_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic int obs_at(input int i);
        return (i < obs_q.size()) ? obs_q[i] : -1;
    endfunction

    function automatic int exp_at(input int i);
        return (i < exp_q.size()) ? exp_q[i] : -1;
    endfunction

    // Gesture-level reference: works on edge timestamps, not on a cycle-by-cycle state machine.
    function automatic int next_press(input int from);
        for (int i = (from < 1) ? 1 : from; i < key_arr.size(); i++)
            if (key_arr[i-1] && !key_arr[i]) return i;
        return -1;
    endfunction

    function automatic int next_release(input int from);
        for (int i = from + 1; i < key_arr.size(); i++)
            if (key_arr[i] && !key_arr[i-1]) return i;
        return BIG;
    endfunction

    function automatic void add_ev(input int t, input int kind);
        if (t < key_arr.size()) exp_q.push_back(ev(t, kind));
    endfunction

    function automatic void model();
        int t, p, r, p2, r2;
        key_arr.delete();
        exp_q.delete();
        foreach (seg_len[i]) for (int k = 0; k < seg_len[i]; k++) key_arr.push_back(seg_lvl[i]);
        t = 1;
        while (t < key_arr.size()) begin
            p = next_press(t);
            if (p < 0) break;
            r = next_release(p);
            if (r > p + L) begin
                add_ev(p + 1 + L, 1);
                for (int x = p + 1 + L + P; x <= r && x < key_arr.size(); x += P) add_ev(x, 2);
                t = (r == BIG) ? BIG : r + 1;
            end else begin
                p2 = next_press(r + 1);
                if (p2 >= 0 && p2 <= r + D) begin
                    add_ev(p2 + 1, 3);
                    r2 = next_release(p2);
                    t = (r2 == BIG) ? BIG : r2 + 1;
                end else begin
                    add_ev(r + 1 + D, 0);
                    t = r + 1 + D;
                end
            end
        end
    endfunction

    function automatic int rand_len();
        case ($urandom_range(0, 3))
            0:       return $urandom_range(1, 30);
            1:       return $urandom_range(45, 55);
            2:       return $urandom_range(195, 205);
            default: return $urandom_range(230, 330);
        endcase
    endfunction

    task automatic test_reset();
        int d;
        RST_n = 1'b0;
        Key_In = 1'b1;
        #3;
        checks++;
        if ({Short_Sig, Long_Sig, Repeat_Sig, Double_Sig} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0000", {Short_Sig, Long_Sig, Repeat_Sig, Double_Sig});
        end
        checks++;
        if (dut.state !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d want %0d", dut.state, IDLE);
        end
        start(1'b1);
        seg(1'b1, 100);
        play();
        checks++;
        d = first_diff();
        if (d >= 0) begin
            errors++;
            $display("FAIL idle_quiet: event %0d got %0d want %0d", d, obs_at(d), exp_at(d));
        end
    endtask

    task automatic test_short();
        int d;
        start(1'b1);
        seg(1'b1, 10); seg(1'b0, 50); seg(1'b1, 200);
        play();
        exp_q.push_back(ev(60 + 51, 0));
        checks++;
        d = first_diff();
        if (d >= 0) begin
            errors++;
            $display("FAIL short_press: event %0d got %0d want %0d", d, obs_at(d), exp_at(d));
        end
    endtask

    task automatic test_double();
        int d;
        start(1'b1);
        seg(1'b1, 10); seg(1'b0, 30); seg(1'b1, 20); seg(1'b0, 30); seg(1'b1, 200);
        play();
        exp_q.push_back(ev(60 + 1, 3));
        checks++;
        d = first_diff();
        if (d >= 0) begin
            errors++;
            $display("FAIL double_click: event %0d got %0d want %0d", d, obs_at(d), exp_at(d));
        end
    endtask

    task automatic test_long_repeat();
        int d;
        start(1'b1);
        seg(1'b1, 10); seg(1'b0, 500); seg(1'b1, 200);
        play();
        exp_q.push_back(ev(10 + 201, 1));
        for (int k = 0; k < 7; k++) exp_q.push_back(ev(10 + 241 + 40 * k, 2));
        checks++;
        d = first_diff();
        if (d >= 0) begin
            errors++;
            $display("FAIL long_repeat: event %0d got %0d want %0d", d, obs_at(d), exp_at(d));
        end
        checks++;
        if (multi_hot !== 0) begin
            errors++;
            $display("FAIL long_onehot: got %0d multi-pulse cycles want 0", multi_hot);
        end
    endtask

    task automatic test_boundary();
        int d;
        // Release coincides with the long timeout: release wins.
        start(1'b1);
        seg(1'b1, 10); seg(1'b0, 200); seg(1'b1, 300);
        play();
        exp_q.push_back(ev(210 + 51, 0));
        checks++;
        d = first_diff();
        if (d >= 0) begin
            errors++;
            $display("FAIL hold_199: event %0d got %0d want %0d", d, obs_at(d), exp_at(d));
        end
        start(1'b1);
        seg(1'b1, 10); seg(1'b0, 201); seg(1'b1, 100);
        play();
        exp_q.push_back(ev(211, 1));
        checks++;
        d = first_diff();
        if (d >= 0) begin
            errors++;
            $display("FAIL hold_200: event %0d got %0d want %0d", d, obs_at(d), exp_at(d));
        end
        // Second press lands on the double timeout: press wins.
        start(1'b1);
        seg(1'b1, 10); seg(1'b0, 30); seg(1'b1, 50); seg(1'b0, 20); seg(1'b1, 200);
        play();
        exp_q.push_back(ev(91, 3));
        checks++;
        d = first_diff();
        if (d >= 0) begin
            errors++;
            $display("FAIL gap_49: event %0d got %0d want %0d", d, obs_at(d), exp_at(d));
        end
        start(1'b1);
        seg(1'b1, 10); seg(1'b0, 30); seg(1'b1, 51); seg(1'b0, 20); seg(1'b1, 200);
        play();
        exp_q.push_back(ev(91, 0));
        exp_q.push_back(ev(111 + 51, 0));
        checks++;
        d = first_diff();
        if (d >= 0) begin
            errors++;
            $display("FAIL gap_50: event %0d got %0d want %0d", d, obs_at(d), exp_at(d));
        end
    endtask

    task automatic test_held_at_reset();
        int d;
        start(1'b0);
        seg(1'b0, 300); seg(1'b1, 20); seg(1'b0, 30); seg(1'b1, 200);
        play();
        exp_q.push_back(ev(350 + 51, 0));
        checks++;
        d = first_diff();
        if (d >= 0) begin
            errors++;
            $display("FAIL held_at_reset: event %0d got %0d want %0d", d, obs_at(d), exp_at(d));
        end
    endtask

    task automatic test_reset_mid_hold();
        int d;
        start(1'b1);
        seg(1'b1, 10); seg(1'b0, 201);
        play();
        checks++;
        if (Long_Sig !== 1'b1) begin
            errors++;
            $display("FAIL long_before_reset: got %b want 1", Long_Sig);
        end
        #2 RST_n = 1'b0;
        #1;
        checks++;
        if ({Short_Sig, Long_Sig, Repeat_Sig, Double_Sig} !== 4'b0000) begin
            errors++;
            $display("FAIL async_clear: got %b want 0000", {Short_Sig, Long_Sig, Repeat_Sig, Double_Sig});
        end
        start(1'b1);
        seg(1'b1, 10); seg(1'b0, 100);
        play();
        #2 RST_n = 1'b0;
        Key_In = 1'b1;
        #1;
        checks++;
        if (dut.state !== IDLE || {Short_Sig, Long_Sig, Repeat_Sig, Double_Sig} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_hold_reset: got state %0d outputs %b want state %0d outputs 0000",
                     dut.state, {Short_Sig, Long_Sig, Repeat_Sig, Double_Sig}, IDLE);
        end
        repeat (2) @(posedge CLK);
        #1;
        RST_n = 1'b1;
        cyc = 0;
        obs_q.delete();
        exp_q.delete();
        seg_lvl.delete();
        seg_len.delete();
        rec = 1;
        seg(1'b1, 300);
        play();
        checks++;
        d = first_diff();
        if (d >= 0 || dut.state !== IDLE) begin
            errors++;
            $display("FAIL after_reset_quiet: event %0d got %0d state %0d want no events state %0d",
                     d, obs_at(d), dut.state, IDLE);
        end
    endtask

    task automatic test_random();
        int d;
        for (int it = 0; it < 4; it++) begin
            start(1'b1);
            seg(1'b1, 5);
            for (int s = 0; s < 30; s++) seg(s[0] ? 1'b1 : 1'b0, rand_len());
            seg(1'b1, 300);
            play();
            model();
            checks++;
            d = first_diff();
            if (d >= 0) begin
                errors++;
                $display("FAIL random_%0d: event %0d got %0d want %0d (counts %0d/%0d)",
                         it, d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
            end
            checks++;
            if (multi_hot !== 0) begin
                errors++;
                $display("FAIL random_onehot_%0d: got %0d multi-pulse cycles want 0", it, multi_hot);
            end
        end
    endtask

    initial begin
        test_reset();
        test_short();
        test_double();
        test_long_repeat();
        test_boundary();
        test_held_at_reset();
        test_reset_mid_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
